// File: rtl/univ_shr.sv
// Universal shift register: hold, shift/rotate/arithmetic shift, parallel load,
// plus an auto-serialize mode that shifts a loaded word out MSB-first.
module univ_shr #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] po,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROTL = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b110;
  localparam logic [2:0] MODE_SER  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last_shift;

  assign last_shift = (cnt_q == CW'(1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      po_q    <= RST_VAL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (mode == MODE_SER) state_d = SHIFT;
        SHIFT:   if (last_shift)       state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and handshake next values; done defaults low so it never stretches
  always_comb begin
    po_d   = po_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          case (mode)
            MODE_HOLD: po_d = po_q;
            MODE_SHL:  po_d = {po_q[WIDTH-2:0], sl_in};
            MODE_SHR:  po_d = {sr_in, po_q[WIDTH-1:1]};
            MODE_ROTL: po_d = {po_q[WIDTH-2:0], po_q[WIDTH-1]};
            MODE_ROTR: po_d = {po_q[0], po_q[WIDTH-1:1]};
            MODE_ASR:  po_d = {po_q[WIDTH-1], po_q[WIDTH-1:1]};
            MODE_LOAD: po_d = pi;
            MODE_SER: begin
              po_d   = pi;
              busy_d = 1'b1;
              cnt_d  = CW'(WIDTH);
            end
            default:   po_d = po_q;
          endcase
        end
        SHIFT: begin
          po_d  = {po_q[WIDTH-2:0], sl_in};
          cnt_d = cnt_q - CW'(1);
          if (last_shift) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign po     = po_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign so_msb = po_q[WIDTH-1];
  assign so_lsb = po_q[0];

endmodule

// File: tb/tb_univ_shr.sv
// Directed bench for univ_shr (WIDTH=4, RST_VAL=0) with hand-computed expectations.
module tb_univ_shr;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] pi;
  logic       sl_in;
  logic       sr_in;
  logic [3:0] po;
  logic       so_msb;
  logic       so_lsb;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  univ_shr #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .pi     (pi),
    .sl_in  (sl_in),
    .sr_in  (sr_in),
    .po     (po),
    .so_msb (so_msb),
    .so_lsb (so_lsb),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] val);
    mode = 3'b110;
    pi   = val;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset has priority over load
    rst = 1'b1; en = 1'b1; mode = 3'b110; pi = 4'b1111; sl_in = 1'b0; sr_in = 1'b0;
    tick(); tick();
    chk("reset_po",   po,         4'b0000);
    chk("reset_busy", 4'(busy),   4'd0);
    chk("reset_done", 4'(done),   4'd0);
    rst = 1'b0;

    // 2. load and enable freeze
    load(4'b1011);
    chk("load_po", po, 4'b1011);
    en = 1'b0; pi = 4'b0000;
    tick(); tick(); tick();
    chk("en0_freeze", po, 4'b1011);
    en = 1'b1;

    // 3. shift modes from 1001
    load(4'b1001);
    chk("so_msb_1001", 4'(so_msb), 4'd1);
    chk("so_lsb_1001", 4'(so_lsb), 4'd1);
    mode = 3'b001; sl_in = 1'b1; tick();
    chk("shl", po, 4'b0011);
    sl_in = 1'b0;
    load(4'b1001);
    mode = 3'b010; sr_in = 1'b1; tick();
    chk("shr", po, 4'b1100);
    sr_in = 1'b0;
    load(4'b1001);
    mode = 3'b011; tick();
    chk("rotl", po, 4'b0011);
    load(4'b1001);
    mode = 3'b100; tick();
    chk("rotr", po, 4'b1100);
    load(4'b1001);
    mode = 3'b101; tick();
    chk("asr_neg", po, 4'b1100);
    load(4'b0110);
    mode = 3'b101; tick();
    chk("asr_pos", po, 4'b0011);
    chk("so_msb_0011", 4'(so_msb), 4'd0);
    chk("so_lsb_0011", 4'(so_lsb), 4'd1);
    mode = 3'b000; tick();
    chk("hold", po, 4'b0011);

    // 4. serialize 1101; load mode applied while busy must be ignored
    mode = 3'b111; pi = 4'b1101; sl_in = 1'b0; tick();
    chk("ser_busy_start", 4'(busy), 4'd1);
    chk("ser_done_start", 4'(done), 4'd0);
    chk("ser_so0", 4'(so_msb), 4'd1);
    mode = 3'b110; pi = 4'b0000;
    tick();
    chk("ser_so1", 4'(so_msb), 4'd1);
    tick();
    chk("ser_so2", 4'(so_msb), 4'd0);
    chk("ser_po2", po, 4'b0100);
    tick();
    chk("ser_so3", 4'(so_msb), 4'd1);
    chk("ser_busy3", 4'(busy), 4'd1);
    chk("ser_done3", 4'(done), 4'd0);
    mode = 3'b000;
    tick();
    chk("ser_po_end",   po,       4'b0000);
    chk("ser_busy_end", 4'(busy), 4'd0);
    chk("ser_done_end", 4'(done), 4'd1);
    tick();
    chk("ser_done_pulse", 4'(done), 4'd0);

    // 5. stall for 2 cycles after the 2nd shift
    mode = 3'b111; pi = 4'b1101; tick();
    mode = 3'b000; pi = 4'b0000;
    chk("stall_so0", 4'(so_msb), 4'd1);
    tick();
    chk("stall_so1", 4'(so_msb), 4'd1);
    tick();
    chk("stall_so2", 4'(so_msb), 4'd0);
    en = 1'b0;
    tick();
    chk("stall_po_a",   po,       4'b0100);
    chk("stall_busy_a", 4'(busy), 4'd1);
    tick();
    chk("stall_po_b",   po,       4'b0100);
    chk("stall_done_b", 4'(done), 4'd0);
    en = 1'b1;
    tick();
    chk("stall_so3",  4'(so_msb), 4'd1);
    chk("stall_busy3", 4'(busy),  4'd1);
    tick();
    chk("stall_done", 4'(done), 4'd1);
    chk("stall_busy", 4'(busy), 4'd0);
    en = 1'b0;
    tick();
    chk("done_clr_en0", 4'(done), 4'd0);
    en = 1'b1;

    // 6. abort mid-serialize, then a clean serialize of 0110
    mode = 3'b111; pi = 4'b1101; tick();
    mode = 3'b000;
    tick(); tick();
    chk("abort_pre_po", po, 4'b0100);
    rst = 1'b1; tick();
    chk("abort_po",   po,       4'b0000);
    chk("abort_busy", 4'(busy), 4'd0);
    chk("abort_done", 4'(done), 4'd0);
    rst = 1'b0;
    tick();
    chk("abort_done_a", 4'(done), 4'd0);
    tick();
    chk("abort_done_b", 4'(done), 4'd0);
    chk("abort_po_b",   po,       4'b0000);
    mode = 3'b111; pi = 4'b0110; tick();
    mode = 3'b000;
    chk("re_busy", 4'(busy),   4'd1);
    chk("re_so0",  4'(so_msb), 4'd0);
    tick();
    chk("re_so1",  4'(so_msb), 4'd1);
    tick();
    chk("re_so2",  4'(so_msb), 4'd1);
    tick();
    chk("re_so3",  4'(so_msb), 4'd0);
    tick();
    chk("re_done", 4'(done), 4'd1);
    chk("re_busy_end", 4'(busy), 4'd0);
    chk("re_po_end", po, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
